half_rate_tracker_mc: RTL

Multi-channel, parametrised half-rate recovery engine for clks_alot. Each channel does the following:
- measures the duration of one clock level (the half-period), in system clock cycles;
- applies an optional polarity filter;
- narrows a per-channel acceptance window from the configured min/max limits toward the measured rate;
- declares lock after N consecutive in-band measurements;
- flags over-/under-frequency violations, including a no-edge timeout.

It sits between the per-channel edge sensors and the clock-regeneration logic.

---
 rtl/half_rate_tracker_mc_if.sv | 34 +++
 rtl/half_rate_tracker_mc.sv | 132 +++++++++++++
 2 files changed

// File: rtl/half_rate_tracker_mc_if.sv
// Bundle of the per-channel sense, configuration and status signals of the
// half-rate tracker. The sensor/config side uses master; the tracker uses slave.
interface half_rate_tracker_mc_if #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNTER_WIDTH = 16
);
    logic                              clk_en_i;
    logic [CHANNELS-1:0]               recovery_en_i;
    logic [CHANNELS-1:0]               polarity_en_i;
    logic [CHANNELS-1:0]               polarity_i;
    logic [CHANNELS-1:0]               clear_state_i;
    logic [COUNTER_WIDTH-1:0]          min_rate_i;
    logic [COUNTER_WIDTH-1:0]          max_rate_i;
    logic [CHANNELS-1:0]               sense_event_i;
    logic [CHANNELS-1:0]               sense_level_i;
    logic [CHANNELS*COUNTER_WIDTH-1:0] current_rate_o;
    logic [CHANNELS-1:0]               locked_o;
    logic [CHANNELS-1:0]               over_frequency_violation_o;
    logic [CHANNELS-1:0]               under_frequency_violation_o;

    modport master (
        output clk_en_i, recovery_en_i, polarity_en_i, polarity_i, clear_state_i,
        output min_rate_i, max_rate_i, sense_event_i, sense_level_i,
        input  current_rate_o, locked_o,
        input  over_frequency_violation_o, under_frequency_violation_o
    );

    modport slave (
        input  clk_en_i, recovery_en_i, polarity_en_i, polarity_i, clear_state_i,
        input  min_rate_i, max_rate_i, sense_event_i, sense_level_i,
        output current_rate_o, locked_o,
        output over_frequency_violation_o, under_frequency_violation_o
    );
endinterface

// File: rtl/half_rate_tracker_mc.sv
// Multi-channel half-rate tracker: measures one clock level per channel in
// system-clock cycles, narrows an acceptance window toward the measured rate,
// declares lock after consecutive in-band measurements and flags
// over/under-frequency (including a no-edge timeout).
module half_rate_tracker_mc #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned LOCK_SHIFT    = 2,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    half_rate_tracker_mc_if.slave bus
);
    localparam int unsigned W   = COUNTER_WIDTH;
    localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);

    // Per-channel state
    logic [W-1:0]        cnt_q      [CHANNELS];
    logic [W-1:0]        lo_q       [CHANNELS];
    logic [W-1:0]        hi_q       [CHANNELS];
    logic [LCW-1:0]      lock_cnt_q [CHANNELS];
    logic [CHANNELS-1:0] armed_q;

    // Registered outputs
    logic [CHANNELS*W-1:0] rate_q;
    logic [CHANNELS-1:0]   locked_q;
    logic [CHANNELS-1:0]   over_q;
    logic [CHANNELS-1:0]   under_q;

    // Per-channel combinational helpers
    logic [W-1:0]        meas      [CHANNELS];
    logic [W-1:0]        lo_step   [CHANNELS];
    logic [W-1:0]        hi_step   [CHANNELS];
    logic [LCW-1:0]      lock_next [CHANNELS];
    logic [CHANNELS-1:0] evaluate;
    logic [CHANNELS-1:0] timeout;

    assign bus.current_rate_o              = rate_q;
    assign bus.locked_o                    = locked_q;
    assign bus.over_frequency_violation_o  = over_q;
    assign bus.under_frequency_violation_o = under_q;

    // Measurement, window steps, lock count advance and timeout detection.
    always_comb begin
        meas      = '{default: '0};
        lo_step   = '{default: '0};
        hi_step   = '{default: '0};
        lock_next = '{default: '0};
        evaluate  = '0;
        timeout   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            // Saturating increment doubles as the idle-cycle counter update.
            meas[k]      = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + W'(1);
            lo_step[k]   = (meas[k] - lo_q[k]) >> LOCK_SHIFT;
            hi_step[k]   = (hi_q[k] - meas[k]) >> LOCK_SHIFT;
            lock_next[k] = (lock_cnt_q[k] >= LCW'(LOCK_COUNT)) ? LCW'(LOCK_COUNT)
                                                              : lock_cnt_q[k] + LCW'(1);
            evaluate[k]  = armed_q[k] &&
                           (!bus.polarity_en_i[k] || (bus.sense_level_i[k] == bus.polarity_i[k]));
            // Fires only on the step to max+1; the counter then runs past max
            // until the next event, so the pulse cannot repeat.
            timeout[k]   = (cnt_q[k] == bus.max_rate_i) && (cnt_q[k] != '1);
        end
    end

    // Per-channel tracking state machine and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                cnt_q[k]      <= '0;
                lo_q[k]       <= '0;
                hi_q[k]       <= '0;
                lock_cnt_q[k] <= '0;
            end
            armed_q  <= '0;
            rate_q   <= '0;
            locked_q <= '0;
            over_q   <= '0;
            under_q  <= '0;
        end else if (bus.clk_en_i) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                over_q[k]  <= 1'b0;
                under_q[k] <= 1'b0;
                if (!bus.recovery_en_i[k] || bus.clear_state_i[k]) begin
                    cnt_q[k]      <= '0;
                    armed_q[k]    <= 1'b0;
                    lock_cnt_q[k] <= '0;
                    locked_q[k]   <= 1'b0;
                    lo_q[k]       <= bus.min_rate_i;
                    hi_q[k]       <= bus.max_rate_i;
                end else if (bus.sense_event_i[k]) begin
                    cnt_q[k] <= '0;
                    if (!armed_q[k]) begin
                        armed_q[k] <= 1'b1;
                        lo_q[k]    <= bus.min_rate_i;
                        hi_q[k]    <= bus.max_rate_i;
                    end else if (evaluate[k]) begin
                        if ((meas[k] < lo_q[k]) || (meas[k] > hi_q[k])) begin
                            over_q[k]     <= (meas[k] < lo_q[k]);
                            under_q[k]    <= (meas[k] > hi_q[k]);
                            lock_cnt_q[k] <= '0;
                            locked_q[k]   <= 1'b0;
                            lo_q[k]       <= bus.min_rate_i;
                            hi_q[k]       <= bus.max_rate_i;
                        end else begin
                            rate_q[k*W +: W] <= meas[k];
                            lo_q[k]          <= lo_q[k] + lo_step[k];
                            hi_q[k]          <= hi_q[k] - hi_step[k];
                            lock_cnt_q[k]    <= lock_next[k];
                            locked_q[k]      <= (lock_next[k] == LCW'(LOCK_COUNT));
                        end
                    end
                end else begin
                    cnt_q[k] <= meas[k];
                    // Until armed, the window follows the configured limits.
                    if (!armed_q[k]) begin
                        lo_q[k] <= bus.min_rate_i;
                        hi_q[k] <= bus.max_rate_i;
                    end
                    if (timeout[k]) begin
                        under_q[k]    <= 1'b1;
                        lock_cnt_q[k] <= '0;
                        locked_q[k]   <= 1'b0;
                        lo_q[k]       <= bus.min_rate_i;
                        hi_q[k]       <= bus.max_rate_i;
                    end
                end
            end
        end
    end
endmodule
